fp_dp_fix2fp: RTL and testbench

- Pipelined converter from a 64-bit integer (signed or unsigned) to an IEEE-754 binary64 value.
- It is the inverse of the double-precision float-to-fixed path in the FPU.
- It sits in the FPU lane alongside the other dp conversion units. It receives integer operands from the operand-fetch stage and returns the result, with a valid flag and a passthrough tag, to the FPU writeback mux.
- Rounding is round-to-nearest-even. There is no stall input: the pipeline advances every cycle.

---
 rtl/fp_dp_fix2fp.sv | 138 +++++++++++++
 tb/tb_fp_dp_fix2fp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_dp_fix2fp.sv
// Pipelined 64-bit integer (signed/unsigned) to IEEE-754 binary64 converter.
// Round-to-nearest-even, 4-cycle latency from acceptance, one op per cycle, no stall.
module fp_dp_fix2fp #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] op0,
    input  logic                  op_signed,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] res,
    output logic [TAG_WIDTH-1:0]  tag_out
);

    // acceptance registers
    logic                  v0;
    logic [DATA_WIDTH-1:0] op0_q;
    logic                  signed_q;
    logic [TAG_WIDTH-1:0]  tag0;

    // stage 1: sign / magnitude
    logic                  v1;
    logic                  sign1;
    logic [DATA_WIDTH-1:0] mag1;
    logic [TAG_WIDTH-1:0]  tag1;

    // stage 2: leading-zero count
    logic                  v2;
    logic                  sign2;
    logic [DATA_WIDTH-1:0] mag2;
    logic [6:0]            lzc2;
    logic                  zero2;
    logic [TAG_WIDTH-1:0]  tag2;

    // stage 3: normalized value without its implicit leading one
    logic                  v3;
    logic                  sign3;
    logic [62:0]           nrm3;
    logic [10:0]           exp3;
    logic                  zero3;
    logic [TAG_WIDTH-1:0]  tag3;

    logic                  sign_c;
    logic [DATA_WIDTH-1:0] mag_c;
    logic [6:0]            lzc_c;
    logic [62:0]           nrm_c;
    logic [10:0]           exp_c;
    logic                  round_up;
    logic [52:0]           mant_sum;
    logic [10:0]           exp_r;
    logic [DATA_WIDTH-1:0] res_c;

    always_comb begin
        sign_c = signed_q & op0_q[63];
        mag_c  = sign_c ? (~op0_q + 64'd1) : op0_q;
    end

    // Last set bit wins, so the highest set bit determines the count.
    always_comb begin
        lzc_c = 7'd64;
        for (int unsigned i = 0; i < 64; i++) begin
            if (mag1[i]) lzc_c = 7'(63 - i);
        end
    end

    always_comb begin
        nrm_c = 63'(mag2 << lzc2);
        exp_c = 11'd1086 - {4'd0, lzc2};
    end

    // A carry out of the 52-bit mantissa leaves mant_sum[51:0] at zero and bumps the exponent.
    always_comb begin
        round_up = nrm3[10] & ((|nrm3[9:0]) | nrm3[11]);
        mant_sum = {1'b0, nrm3[62:11]} + {52'd0, round_up};
        exp_r    = mant_sum[52] ? (exp3 + 11'd1) : exp3;
        res_c    = zero3 ? '0 : {sign3, exp_r, mant_sum[51:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0        <= 1'b0;
            op0_q     <= '0;
            signed_q  <= 1'b0;
            tag0      <= '0;
            v1        <= 1'b0;
            sign1     <= 1'b0;
            mag1      <= '0;
            tag1      <= '0;
            v2        <= 1'b0;
            sign2     <= 1'b0;
            mag2      <= '0;
            lzc2      <= '0;
            zero2     <= 1'b0;
            tag2      <= '0;
            v3        <= 1'b0;
            sign3     <= 1'b0;
            nrm3      <= '0;
            exp3      <= '0;
            zero3     <= 1'b0;
            tag3      <= '0;
            valid_out <= 1'b0;
            res       <= '0;
            tag_out   <= '0;
        end else begin
            v0        <= valid_in;
            op0_q     <= op0;
            signed_q  <= op_signed;
            tag0      <= tag_in;

            v1        <= v0;
            sign1     <= sign_c;
            mag1      <= mag_c;
            tag1      <= tag0;

            v2        <= v1;
            sign2     <= sign1;
            mag2      <= mag1;
            lzc2      <= lzc_c;
            zero2     <= (mag1 == '0);
            tag2      <= tag1;

            v3        <= v2;
            sign3     <= sign2;
            nrm3      <= nrm_c;
            exp3      <= exp_c;
            zero3     <= zero2;
            tag3      <= tag2;

            valid_out <= v3;
            res       <= res_c;
            tag_out   <= tag3;
        end
    end

endmodule

// File: tb/tb_fp_dp_fix2fp.sv
// Scoreboard bench for fp_dp_fix2fp: driver pushes expected results with their due cycle,
// a negedge monitor pops and compares whenever an output is due or presented.
module tb_fp_dp_fix2fp;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [63:0] op0;
    logic        op_signed;
    logic [7:0]  tag_in;
    logic        valid_out;
    logic [63:0] res;
    logic [7:0]  tag_out;

    typedef struct {
        logic [63:0] exp_res;
        logic [7:0]  tag;
        int          due;
    } sb_item_t;

    sb_item_t sb[$];
    sb_item_t it;
    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;
    logic     exp_v;
    logic [7:0] next_tag = 8'd0;

    fp_dp_fix2fp #(.DATA_WIDTH(64), .TAG_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .op0(op0),
        .op_signed(op_signed),
        .tag_in(tag_in),
        .valid_out(valid_out),
        .res(res),
        .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Exact binary64 value of an integer, rounded to nearest even via quotient/remainder.
    function automatic logic [63:0] ref_cvt(input logic [63:0] x, input logic sgn);
        logic        neg;
        logic [63:0] mag, q, rem, half;
        int          p, sh;
        neg = sgn && x[63];
        mag = neg ? (64'd0 - x) : x;
        if (mag == 64'd0) return 64'd0;
        p = 63;
        while (!mag[p]) p--;
        if (p <= 52) begin
            q = mag << (52 - p);
        end else begin
            sh   = p - 52;
            q    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 53)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {neg, 11'(1023 + p), q[51:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [63:0] v, input logic s, input logic [63:0] expected);
        sb_item_t n;
        valid_in  = 1'b1;
        op0       = v;
        op_signed = s;
        tag_in    = next_tag;
        n.exp_res = expected;
        n.tag     = next_tag;
        n.due     = cyc + 5;
        sb.push_back(n);
        next_tag  = next_tag + 8'd1;
        step();
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        op0      = {$urandom, $urandom};
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        v = {$urandom, $urandom};
        v = v >> $urandom_range(0, 63);
        if ($urandom_range(0, 3) == 0) v = v | 64'd1 << $urandom_range(53, 63);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (valid_out !== 1'b0 || res !== 64'd0 || tag_out !== 8'd0) begin
                failures++;
                $display("FAIL reset_outputs: got valid_out=%b res=%h tag_out=%h, want 0/0/0",
                         valid_out, res, tag_out);
            end
        end else begin
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            checks++;
            if (valid_out !== exp_v) begin
                failures++;
                $display("FAIL valid_out at cycle %0d: got %b, want %b", cyc, valid_out, exp_v);
            end
            if (exp_v) begin
                it = sb.pop_front();
                if (valid_out === 1'b1) begin
                    checks++;
                    if (res !== it.exp_res) begin
                        failures++;
                        $display("FAIL res tag=%0d: got %h, want %h", it.tag, res, it.exp_res);
                    end
                    checks++;
                    if (tag_out !== it.tag) begin
                        failures++;
                        $display("FAIL tag_out: got %0d, want %0d", tag_out, it.tag);
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] v;
        logic        s;
        rst       = 1'b0;
        valid_in  = 1'b1;
        op0       = 64'h0123456789ABCDEF;
        op_signed = 1'b1;
        tag_in    = 8'hA5;

        // held in reset with valid_in high
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        valid_in = 1'b0;
        step();

        issue(64'd1, 1'b1, 64'h3FF0000000000000);
        idle(6);

        issue(64'h0000000000000000, 1'b1, 64'h0000000000000000);
        issue(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hBFF0000000000000);
        issue(64'h8000000000000000, 1'b1, 64'hC3E0000000000000);
        issue(64'h0020000000000001, 1'b1, 64'h4340000000000000);
        issue(64'h0020000000000003, 1'b1, 64'h4340000000000002);
        issue(64'h7FFFFFFFFFFFFFFF, 1'b1, 64'h43E0000000000000);
        issue(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h43F0000000000000);
        issue(64'h8000000000000000, 1'b0, 64'h43E0000000000000);
        idle(6);

        for (int i = 0; i < 100; i++) begin
            v = rand_op();
            s = 1'($urandom_range(0, 1));
            issue(v, s, ref_cvt(v, s));
        end
        idle(8);
        for (int i = 0; i < 3; i++) begin
            v = rand_op();
            s = 1'($urandom_range(0, 1));
            issue(v, s, ref_cvt(v, s));
        end
        idle(8);

        // mid-flight reset: none of these three may ever emerge
        for (int i = 0; i < 3; i++) begin
            v = rand_op();
            issue(v, 1'b1, ref_cvt(v, 1'b1));
        end
        rst = 1'b0;
        sb.delete();
        idle(3);
        rst = 1'b1;
        idle(10);
        issue(64'hFFFFFFFFFFFFFFFE, 1'b1, 64'hC000000000000000);
        idle(8);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
